// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 1-to-4 TDM demultiplexer.
package tdm_demux_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam int unsigned   SLOT_W    = 2;
  localparam int unsigned   NUM_LANES = 4;
  localparam logic [SLOT_W-1:0] SLOT_LAST = 2'b11;

  function automatic logic [NUM_LANES-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
    slot_onehot = NUM_LANES'(1) << s;
  endfunction

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot counter: load-to-1 on start of frame, increment with natural wrap 3->0.
module tdm_slot_cnt
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              sel_1,
  output logic              sel_0
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      slot <= '0;
    else if (load1)
      slot <= SLOT_W'(1);
    else if (inc)
      slot <= slot + SLOT_W'(1);
  end

  assign sel_1 = slot[1];
  assign sel_0 = slot[0];

endmodule

// File: rtl/tdm_demux_1_4.sv
// Registered 1-to-4 time-division demultiplexer with start-of-frame alignment.
module tdm_demux_1_4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned WIDTH         = 1,
  parameter bit          RESYNC_ON_SOF = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       out_valid,
  output logic             sel_1,
  output logic             sel_0,
  output logic             frame_done,
  output logic             sync_err
);

  state_t                 state, state_nxt;
  logic [SLOT_W-1:0]      slot;
  logic                   cnt_load, cnt_inc;
  logic [NUM_LANES-1:0]   wr_en;
  logic                   done_nxt, err_nxt;
  logic [WIDTH-1:0]       lane [NUM_LANES];

  tdm_slot_cnt u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load1 (cnt_load),
    .inc   (cnt_inc),
    .slot  (slot),
    .sel_1 (sel_1),
    .sel_0 (sel_0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = '0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (in_valid) begin
      case (state)
        ST_IDLE: begin
          if (in_sof) begin
            wr_en     = slot_onehot(SLOT_W'(0));
            cnt_load  = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
        ST_RUN: begin
          err_nxt = in_sof;
          // Without resync a stray sof beat simply fills the current slot.
          if (in_sof && RESYNC_ON_SOF) begin
            wr_en    = slot_onehot(SLOT_W'(0));
            cnt_load = 1'b1;
          end else begin
            wr_en   = slot_onehot(slot);
            cnt_inc = 1'b1;
            if (slot == SLOT_LAST) begin
              done_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LANES; i++)
        lane[i] <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++)
        if (wr_en[i])
          lane[i] <= in_data;
      out_valid  <= wr_en;
      frame_done <= done_nxt;
      sync_err   <= err_nxt;
    end
  end

  assign o0 = lane[0];
  assign o1 = lane[1];
  assign o2 = lane[2];
  assign o3 = lane[3];

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Self-checking bench: two demux instances (resync on / off) against a frame-level model.
module tb_tdm_demux_1_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [3:0] din = '0;

  logic [0:0] o0a, o1a, o2a, o3a;
  logic [3:0] o0b, o1b, o2b, o3b;
  logic [3:0] ova, ovb;
  logic       s1a, s0a, s1b, s0b, fda, fdb, sea, seb;

  int npass = 0;
  int ntot  = 0;

  // model: per instance, whether a frame is open, next slot, lane contents, pulses
  int act [2];
  int slt [2];
  int ln  [2][4];
  int mov [2];
  int mfd [2];
  int mse [2];

  always #5 clk = ~clk;

  tdm_demux_1_4 #(.WIDTH(1), .RESYNC_ON_SOF(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(din[0:0]),
    .o0(o0a), .o1(o1a), .o2(o2a), .o3(o3a), .out_valid(ova),
    .sel_1(s1a), .sel_0(s0a), .frame_done(fda), .sync_err(sea)
  );

  tdm_demux_1_4 #(.WIDTH(4), .RESYNC_ON_SOF(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(din),
    .o0(o0b), .o1(o1b), .o2(o2b), .o3(o3b), .out_valid(ovb),
    .sel_1(s1b), .sel_0(s0b), .frame_done(fdb), .sync_err(seb)
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s dut%0d observed=%0h expected=%0h t=%0t", tag, k, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; slt[k] = 0; mov[k] = 0; mfd[k] = 0; mse[k] = 0;
      for (int i = 0; i < 4; i++) ln[k][i] = 0;
    end
  endtask

  // One accepted-beat rule set, expressed in terms of frame position.
  task automatic model_beat(input int k, input bit resync, input bit v, input bit s, input int d);
    mov[k] = 0; mfd[k] = 0; mse[k] = 0;
    if (!v) return;
    if (act[k] == 0) begin
      if (s) begin
        ln[k][0] = d; mov[k] = 1; slt[k] = 1; act[k] = 1;
      end else begin
        mse[k] = 1;
      end
    end else begin
      if (s) mse[k] = 1;
      if (s && resync) begin
        ln[k][0] = d; mov[k] = 1; slt[k] = 1;
      end else begin
        ln[k][slt[k]] = d;
        mov[k] = 2 ** slt[k];
        if (slt[k] == 3) begin
          mfd[k] = 1; slt[k] = 0; act[k] = 0;
        end else begin
          slt[k] = slt[k] + 1;
        end
      end
    end
  endtask

  task automatic chk_dut(input int k, input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] a3, input logic [3:0] ov, input logic [1:0] sel,
                         input logic fd, input logic se);
    chk("o0", k, 32'(a0), ln[k][0]);
    chk("o1", k, 32'(a1), ln[k][1]);
    chk("o2", k, 32'(a2), ln[k][2]);
    chk("o3", k, 32'(a3), ln[k][3]);
    chk("out_valid", k, 32'(ov), mov[k]);
    chk("sel", k, 32'(sel), slt[k]);
    chk("frame_done", k, 32'(fd), mfd[k]);
    chk("sync_err", k, 32'(se), mse[k]);
  endtask

  task automatic check_all();
    chk_dut(0, 4'(o0a), 4'(o1a), 4'(o2a), 4'(o3a), ova, {s1a, s0a}, fda, sea);
    chk_dut(1, o0b, o1b, o2b, o3b, ovb, {s1b, s0b}, fdb, seb);
  endtask

  task automatic step(input bit v, input bit s, input logic [3:0] d);
    @(negedge clk);
    in_valid = v; in_sof = s; din = d;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      model_beat(0, 1'b1, v, s, int'(d[0]));
      model_beat(1, 1'b0, v, s, int'(d));
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, released on the next falling edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // reset held with toggling inputs
    for (int i = 0; i < 4; i++) step(1'b1, i[0], 4'(i + 5));
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    idle(2);

    // back-to-back frame 1,0,1,0
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b0, 4'h0);
    idle(1);

    // same frame with two-cycle gaps
    step(1'b1, 1'b1, 4'h1); idle(2);
    step(1'b1, 1'b0, 4'h0); idle(2);
    step(1'b1, 1'b0, 4'h1); idle(2);
    step(1'b1, 1'b0, 4'h0); idle(2);

    // non-sof beat while idle
    step(1'b1, 1'b0, 4'hF);
    idle(1);

    // mid-frame sof: resync on one instance, data on the other
    step(1'b1, 1'b1, 4'hB);
    step(1'b1, 1'b0, 4'hD);
    step(1'b1, 1'b0, 4'h7);
    step(1'b1, 1'b1, 4'h2);
    step(1'b1, 1'b0, 4'h9);
    step(1'b1, 1'b0, 4'h4);
    step(1'b1, 1'b0, 4'hE);
    idle(1);

    // reset after slot 1 of a frame, then a clean frame
    step(1'b1, 1'b1, 4'h3);
    step(1'b1, 1'b0, 4'h5);
    async_reset();
    step(1'b1, 1'b1, 4'hA);
    step(1'b1, 1'b0, 4'h6);
    step(1'b1, 1'b0, 4'hC);
    step(1'b1, 1'b0, 4'h1);
    idle(1);

    // randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), 4'($urandom));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #1000000;
    ntot++;
    $display("FAIL timeout observed=running expected=finished");
    $display("%0d/%0d checks passed", npass, ntot);
    $fatal(1, "timeout");
  end

endmodule
